// File: rtl/bus_pkg.sv
// Shared bit-serial bus definitions: FSM states, mode codes, default widths.
// Used by the slave port, the master and the command processor.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WAIT,
        RDATA
    } bus_state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int BUS_ADDR_WIDTH   = 4;
    localparam int BUS_DATA_WIDTH   = 8;
    localparam int BUS_MEM_DEPTH    = 16;
    localparam int BUS_READ_LATENCY = 2;

endpackage

// File: rtl/bus_slave_port_if.sv
// Bit-serial bus signals between one master and one slave port.
// Scalar clock and reset travel outside the interface.
interface bus_slave_port_if;

    logic valid;
    logic mode;
    logic s_in;
    logic ready;
    logic s_out;
    logic s_out_valid;
    logic error;

    modport master (
        output valid,
        output mode,
        output s_in,
        input  ready,
        input  s_out,
        input  s_out_valid,
        input  error
    );

    modport slave (
        input  valid,
        input  mode,
        input  s_in,
        output ready,
        output s_out,
        output s_out_valid,
        output error
    );

endinterface

// File: rtl/bus_slave_mem.sv
// Slave register array: async clear, one sync write port, one comb read port.
// Addresses at or above DEPTH never match: writes dropped, reads return 0.
module bus_slave_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Word storage: cleared on reset, written on the addressed word only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_waddr == ADDR_WIDTH'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Read mux; unmatched addresses yield zero
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == ADDR_WIDTH'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/bus_slave_port.sv
// Bit-serial bus slave: deserialises mode/address/data, writes or reads memory.
// Optional BUS_SLAVE_PARITY_EN adds an even-parity bit to writes and reads.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH   = BUS_DATA_WIDTH,
    parameter int MEM_DEPTH    = BUS_MEM_DEPTH,
    parameter int READ_LATENCY = BUS_READ_LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    bus_slave_port_if.slave  bus
);

`ifdef BUS_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WBITS = DATA_WIDTH + PAR_BITS;
    localparam int RBITS = DATA_WIDTH + PAR_BITS;
    localparam int CW    = $clog2(ADDR_WIDTH + WBITS + READ_LATENCY + 1);

    bus_state_e            r_state;
    bus_state_e            w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nx;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wsh;
    logic [RBITS-1:0]      r_osh;
    logic                  r_s_out;
    logic                  r_s_out_valid;
    logic                  r_ready;
    logic                  r_error;

    logic                  w_err_nx;
    logic                  w_we;
    logic                  w_load;
    logic                  w_oor;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata_mem;
    logic [RBITS-1:0]      w_rword;

    assign w_oor = (32'(r_addr) >= MEM_DEPTH);

`ifdef BUS_SLAVE_PARITY_EN
    logic w_par_ok;
    // Write data is complete in the shift register when the parity bit arrives
    assign w_wdata  = r_wsh;
    assign w_par_ok = (bus.s_in == ^{r_addr, r_wsh});
    assign w_rword  = {^w_rdata_mem, w_rdata_mem};
`else
    // Last data bit is still on s_in during the final WDATA cycle
    assign w_wdata  = {bus.s_in, r_wsh[DATA_WIDTH-1:1]};
    assign w_rword  = w_rdata_mem;
`endif

    bus_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata_mem)
    );

    // Next-state, bit counter, write strobe, read load and error decision
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_err_nx   = 1'b0;
        w_we       = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (bus.valid) begin
                    w_state_nx = ADDR;
                end
            end
            ADDR: begin
                if (!bus.valid) begin
                    w_state_nx = IDLE;
                    w_err_nx   = 1'b1;
                end else if (r_cnt == CW'(ADDR_WIDTH - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (r_mode == MODE_WRITE) ? WDATA : WAIT;
                end
            end
            WDATA: begin
                if (!bus.valid) begin
                    w_state_nx = IDLE;
                    w_err_nx   = 1'b1;
                end else if (r_cnt == CW'(WBITS - 1)) begin
                    w_state_nx = IDLE;
`ifdef BUS_SLAVE_PARITY_EN
                    if (w_oor || !w_par_ok) begin
`else
                    if (w_oor) begin
`endif
                        w_err_nx = 1'b1;
                    end else begin
                        w_we = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!bus.valid) begin
                    w_state_nx = IDLE;
                    w_err_nx   = 1'b1;
                end else if (r_cnt == CW'(READ_LATENCY - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = RDATA;
                    w_load     = 1'b1;
                end
            end
            RDATA: begin
                if (r_cnt == CW'(RBITS - 1)) begin
                    w_state_nx = IDLE;
                    w_err_nx   = w_oor;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State register and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Input deserialisation: mode latch, address and write-data shift-in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= MODE_READ;
            r_addr <= '0;
            r_wsh  <= '0;
        end else begin
            if (r_state == IDLE && bus.valid) begin
                r_mode <= bus.mode;
            end
            if (r_state == ADDR && bus.valid) begin
                r_addr <= {bus.s_in, r_addr[ADDR_WIDTH-1:1]};
            end
            if (r_state == WDATA && bus.valid && r_cnt < CW'(DATA_WIDTH)) begin
                r_wsh <= {bus.s_in, r_wsh[DATA_WIDTH-1:1]};
            end
        end
    end

    // Registered outputs and read-data serialiser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready       <= 1'b1;
            r_error       <= 1'b0;
            r_s_out       <= 1'b0;
            r_s_out_valid <= 1'b0;
            r_osh         <= '0;
        end else begin
            r_ready <= (w_state_nx == IDLE);
            r_error <= w_err_nx;
            if (w_load) begin
                r_s_out       <= w_rword[0];
                r_osh         <= w_rword >> 1;
                r_s_out_valid <= 1'b1;
            end else if (r_state == RDATA) begin
                if (w_state_nx == IDLE) begin
                    r_s_out       <= 1'b0;
                    r_s_out_valid <= 1'b0;
                end else begin
                    r_s_out <= r_osh[0];
                    r_osh   <= r_osh >> 1;
                end
            end
        end
    end

    assign bus.ready       = r_ready;
    assign bus.error       = r_error;
    assign bus.s_out       = r_s_out;
    assign bus.s_out_valid = r_s_out_valid;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port (MEM_DEPTH=12, AW=4, DW=8, latency 2).
// Parity steps are included when BUS_SLAVE_PARITY_EN is defined.
module tb_bus_slave_port;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus_slave_port_if bif ();

    bus_slave_port #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (8),
        .MEM_DEPTH    (12),
        .READ_LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d,
                      input logic flip, input logic exp_err);
        bif.valid = 1'b1;
        bif.mode  = 1'b1;
        bif.s_in  = 1'b0;
        chk("wr_c0_ready", 9'(bif.ready), 9'd1);
        tick;
        chk("wr_c1_ready", 9'(bif.ready), 9'd0);
        for (int i = 0; i < 4; i++) begin
            bif.s_in = a[i];
            tick;
        end
        for (int i = 0; i < 8; i++) begin
            bif.s_in = d[i];
            tick;
        end
`ifdef BUS_SLAVE_PARITY_EN
        bif.s_in = (^{a, d}) ^ flip;
        tick;
`endif
        bif.valid = 1'b0;
        bif.mode  = 1'b0;
        bif.s_in  = 1'b0;
        chk("wr_end_ready", 9'(bif.ready), 9'd1);
        chk("wr_end_err", 9'(bif.error), 9'(exp_err));
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d,
                      output logic p, output logic e);
        bif.valid = 1'b1;
        bif.mode  = 1'b0;
        tick;
        chk("rd_c1_err", 9'(bif.error), 9'd0);
        for (int i = 0; i < 4; i++) begin
            bif.s_in = a[i];
            tick;
        end
        for (int i = 0; i < 2; i++) begin
            chk("rd_wait_sov", 9'(bif.s_out_valid), 9'd0);
            tick;
        end
        bif.valid = 1'b0;
        d = '0;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rd_bit_sov", 9'(bif.s_out_valid), 9'd1);
            d[i] = bif.s_out;
            tick;
        end
`ifdef BUS_SLAVE_PARITY_EN
        chk("rd_par_sov", 9'(bif.s_out_valid), 9'd1);
        p = bif.s_out;
        tick;
`endif
        chk("rd_end_ready", 9'(bif.ready), 9'd1);
        chk("rd_end_sov", 9'(bif.s_out_valid), 9'd0);
        chk("rd_end_sout", 9'(bif.s_out), 9'd0);
        e = bif.error;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       e;
        logic [7:0] v;

        reset     = 1'b1;
        bif.valid = 1'b0;
        bif.mode  = 1'b0;
        bif.s_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 9'(bif.ready), 9'd1);
        chk("rst_sout", 9'(bif.s_out), 9'd0);
        chk("rst_sov", 9'(bif.s_out_valid), 9'd0);
        chk("rst_err", 9'(bif.error), 9'd0);
        #2 reset = 1'b0;
        tick;

        wr(4'h3, 8'hAA, 1'b0, 1'b0);
        rd(4'h3, d, p, e);
        chk("rd3_data", 9'(d), 9'h0AA);
        chk("rd3_err", 9'(e), 9'd0);

        v = 8'h55;
        bif.valid = 1'b1;
        bif.mode  = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            bif.s_in = (i == 0 || i == 2);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            bif.s_in = v[i];
            tick;
        end
        bif.valid = 1'b0;
        tick;
        chk("abort_err", 9'(bif.error), 9'd1);
        chk("abort_ready", 9'(bif.ready), 9'd1);
        rd(4'h5, d, p, e);
        chk("abort_mem5", 9'(d), 9'h000);
        chk("abort_rd_err", 9'(e), 9'd0);

        wr(4'h7, 8'h3C, 1'b0, 1'b0);
        rd(4'h7, d, p, e);
        chk("rd7_data", 9'(d), 9'h03C);
        wr(4'h0, 8'hFF, 1'b0, 1'b0);
        wr(4'hB, 8'h81, 1'b0, 1'b0);
        rd(4'h0, d, p, e);
        chk("rd0_data", 9'(d), 9'h0FF);
        rd(4'hB, d, p, e);
        chk("rdB_data", 9'(d), 9'h081);
        rd(4'h3, d, p, e);
        chk("rd3_again", 9'(d), 9'h0AA);

        rd(4'hE, d, p, e);
        chk("oor_rd_data", 9'(d), 9'h000);
        chk("oor_rd_err", 9'(e), 9'd1);
        tick;
        chk("oor_err_pulse", 9'(bif.error), 9'd0);

        wr(4'hC, 8'h5A, 1'b0, 1'b1);
        rd(4'hC, d, p, e);
        chk("oor_wr_rd", 9'(d), 9'h000);
        chk("oor_wr_rd_err", 9'(e), 9'd1);

        bif.valid = 1'b1;
        bif.mode  = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            bif.s_in = (i < 2);
            tick;
        end
        bif.valid = 1'b0;
        tick;
        chk("wait_abort_err", 9'(bif.error), 9'd1);
        chk("wait_abort_sov", 9'(bif.s_out_valid), 9'd0);
        tick;
        chk("wait_abort_pulse", 9'(bif.error), 9'd0);

        bif.valid = 1'b1;
        bif.mode  = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            bif.s_in = (i < 2);
            tick;
        end
        tick;
        tick;
        bif.valid = 1'b0;
        repeat (4) tick;
        chk("rst_mid_sov_pre", 9'(bif.s_out_valid), 9'd1);
        chk("rst_mid_bit4", 9'(bif.s_out), 9'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_sov", 9'(bif.s_out_valid), 9'd0);
        chk("rst_mid_sout", 9'(bif.s_out), 9'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick;
        chk("rst_mid_ready", 9'(bif.ready), 9'd1);
        rd(4'h3, d, p, e);
        chk("rst_mid_mem3", 9'(d), 9'h000);

`ifdef BUS_SLAVE_PARITY_EN
        wr(4'h3, 8'hAA, 1'b1, 1'b1);
        rd(4'h3, d, p, e);
        chk("par_bad_mem3", 9'(d), 9'h000);
        wr(4'h3, 8'hAA, 1'b0, 1'b0);
        rd(4'h3, d, p, e);
        chk("par_ok_mem3", 9'(d), 9'h0AA);
        chk("par_rd_bit", 9'(p), 9'd0);
        wr(4'h1, 8'h01, 1'b0, 1'b0);
        rd(4'h1, d, p, e);
        chk("par_rd_bit1", 9'(p), 9'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
